sipo_word_framer: RTL and testbench



---
 rtl/sipo_word_framer.sv | 106 ++++++++++
 tb/tb_sipo_word_framer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_word_framer.sv
// sipo_word_framer: frame-synced serial-to-parallel word collector with a one-entry valid/ready output buffer; define SIPO_FRAMER_PARITY_EN to add a trailing even-parity bit check
module sipo_word_framer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  input  logic             data_valid,
  input  logic             frame_sync,
  input  logic             DIR,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy,
`ifdef SIPO_FRAMER_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun,
  input  logic             overrun_clr
);
`ifdef SIPO_FRAMER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif
  state_t state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CNT_W-1:0] cnt_n;
  logic dir_l, dir_n, done, pend, load;
`ifdef SIPO_FRAMER_PARITY_EN
  logic perr_n;
`endif
  assign busy = state != IDLE;
  assign load = pend && (!word_valid || word_ready);
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // next state, shift/count and word-completion decode; a sync bit always restarts the frame
  always_comb begin
    state_n = state;
    sr_n = sr;
    cnt_n = bit_cnt;
    dir_n = dir_l;
    done = 1'b0;
`ifdef SIPO_FRAMER_PARITY_EN
    perr_n = 1'b0;
`endif
    if (data_valid && frame_sync) begin
      state_n = SHIFT;
      cnt_n = CNT_W'(1);
      dir_n = DIR;
      sr_n = DIR ? {{(WIDTH-1){1'b0}}, data} : {data, {(WIDTH-1){1'b0}}};
    end else if (data_valid && state == SHIFT) begin
      sr_n = dir_l ? {sr[WIDTH-2:0], data} : {data, sr[WIDTH-1:1]};
      cnt_n = bit_cnt + CNT_W'(1);
      if (bit_cnt == CNT_W'(WIDTH-1)) begin
`ifdef SIPO_FRAMER_PARITY_EN
        state_n = PARITY;
`else
        state_n = IDLE;
        cnt_n = '0;
        done = 1'b1;
`endif
      end
    end
`ifdef SIPO_FRAMER_PARITY_EN
    else if (data_valid && state == PARITY) begin
      state_n = IDLE;
      cnt_n = '0;
      done = data == ^sr;
      perr_n = data != ^sr;
    end
`endif
  end
  // datapath: the completed word waits one cycle in sr (pend) before entering the output buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      bit_cnt <= '0;
      dir_l <= 1'b1;
      pend <= 1'b0;
      word_out <= '0;
      word_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sr <= sr_n;
      bit_cnt <= cnt_n;
      dir_l <= dir_n;
      pend <= done;
      word_out <= load ? sr : word_out;
      word_valid <= load || (word_valid && !word_ready);
      overrun <= (pend && word_valid && !word_ready) || (overrun && !overrun_clr);
    end
  end
`ifdef SIPO_FRAMER_PARITY_EN
  // one-cycle pulse when the parity bit disagrees with the collected word
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else parity_err <= perr_n;
  end
`endif
endmodule

// File: tb/tb_sipo_word_framer.sv
// tb_sipo_word_framer: directed table vectors plus randomized traffic checked against a bit-list reference model
module tb_sipo_word_framer;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1, data = 1'b0, data_valid = 1'b0, frame_sync = 1'b0, DIR = 1'b1;
  logic word_ready = 1'b0, overrun_clr = 1'b0;
  logic [W-1:0] word_out;
  logic word_valid, busy, overrun;
  logic [3:0] bit_cnt;
`ifdef SIPO_FRAMER_PARITY_EN
  logic parity_err;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sipo_word_framer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .frame_sync(frame_sync),
    .DIR(DIR), .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .bit_cnt(bit_cnt), .busy(busy),
`ifdef SIPO_FRAMER_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  // reference model: the frame is a list of received bits, assembled arithmetically when full
  logic fb[$];
  bit in_frame, in_par, mdir, pend, mvalid, movr, mperr;
  logic [W-1:0] pword, mword;

  function automatic logic [W-1:0] build();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) w[mdir ? W-1-i : i] = fb[i];
    return w;
  endfunction

  function automatic void model(bit r, bit dv, bit d, bit fs, bit dir, bit rdy, bit oc);
    bit set;
    if (r) begin
      fb.delete(); in_frame = 0; in_par = 0; mdir = 1; pend = 0;
      mvalid = 0; movr = 0; mword = '0; mperr = 0;
      return;
    end
    set = pend && mvalid && !rdy;
    if (pend && (!mvalid || rdy)) begin mword = pword; mvalid = 1; end
    else if (mvalid && rdy) mvalid = 0;
    movr = set || (movr && !oc);
    pend = 0;
    mperr = 0;
    if (dv) begin
      if (fs) begin
        fb.delete(); fb.push_back(d); mdir = dir; in_frame = 1; in_par = 0;
      end else if (in_par) begin
        if (d == ^pword) pend = 1; else mperr = 1;
        in_par = 0; in_frame = 0; fb.delete();
      end else if (in_frame) begin
        fb.push_back(d);
        if (fb.size() == W) begin
          pword = build();
`ifdef SIPO_FRAMER_PARITY_EN
          in_par = 1;
`else
          pend = 1; in_frame = 0; fb.delete();
`endif
        end
      end
    end
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit dv, bit d, bit fs, bit dir, bit rdy, bit oc);
    @(negedge clk);
    rst = r; data_valid = dv; data = d; frame_sync = fs; DIR = dir;
    word_ready = rdy; overrun_clr = oc;
    model(r, dv, d, fs, dir, rdy, oc);
    @(posedge clk);
    #1;
    chk("word_out", word_out, mword);
    chk("word_valid", word_valid, mvalid);
    chk("bit_cnt", bit_cnt, in_frame ? fb.size() : 0);
    chk("busy", busy, in_frame);
    chk("overrun", overrun, movr);
`ifdef SIPO_FRAMER_PARITY_EN
    chk("parity_err", parity_err, mperr);
`endif
  endtask

  task automatic idle(bit rdy);
    step(0, 0, 0, 0, 1, rdy, 0);
  endtask

  task automatic send(logic [7:0] b, bit dir, bit rdy);
    for (int i = 0; i < 8; i++) step(0, 1, b[7-i], i == 0, dir, rdy, 0);
`ifdef SIPO_FRAMER_PARITY_EN
    step(0, 1, ^b, 0, dir, rdy, 0);
`endif
  endtask

  typedef struct {
    logic [7:0] seq;
    bit dir;
    bit toggle;
    bit gaps;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[4];
    tbl[0] = '{8'b10110010, 1'b1, 1'b0, 1'b0, 8'hB2};
    tbl[1] = '{8'b10110010, 1'b0, 1'b0, 1'b0, 8'h4D};
    tbl[2] = '{8'b10110010, 1'b0, 1'b1, 1'b0, 8'h4D};
    tbl[3] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5};

    step(1, 0, 0, 0, 1, 0, 0);
    chk("reset_word_out", word_out, 0);
    chk("reset_flags", {word_valid, busy, overrun, bit_cnt}, 0);

    foreach (tbl[k]) begin
      for (int i = 0; i < 8; i++) begin
        step(0, 1, tbl[k].seq[7-i], i == 0, (tbl[k].toggle && i >= 3) ? !tbl[k].dir : tbl[k].dir, 1, 0);
        if (tbl[k].gaps && i < 7) begin
          step(0, 0, 1, 0, 1, 1, 0);
          chk("gap_bit_cnt", bit_cnt, i + 1);
        end
      end
`ifdef SIPO_FRAMER_PARITY_EN
      step(0, 1, ^tbl[k].exp, 0, tbl[k].dir, 1, 0);
`endif
      idle(1);
      chk("vec_valid", word_valid, 1);
      chk("vec_word", word_out, tbl[k].exp);
      idle(1);
      chk("vec_valid_drop", word_valid, 0);
    end

    send(8'h11, 1, 0);
    send(8'h22, 1, 0);
    idle(0);
    chk("ovr_word", word_out, 8'h11);
    chk("ovr_flag", overrun, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("ovr_clr", overrun, 0);
    idle(1);
    chk("ovr_drain", word_valid, 0);

    for (int i = 0; i < 5; i++) step(0, 1, 1, i == 0, 1, 1, 0);
    send(8'h3C, 1, 1);
    idle(1);
    chk("resync_word", word_out, 8'h3C);
    chk("resync_ovr", overrun, 0);

    for (int i = 0; i < 4; i++) step(0, 1, 1, i == 0, 1, 1, 0);
    step(1, 0, 0, 0, 1, 1, 0);
    chk("rst_mid_frame", {word_out, word_valid, busy, bit_cnt}, 0);
    send(8'h5A, 1, 0);
    idle(0);
    chk("rst_pre_valid", word_valid, 1);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("rst_with_valid", {word_out, word_valid, overrun}, 0);

`ifdef SIPO_FRAMER_PARITY_EN
    for (int i = 0; i < 8; i++) step(0, 1, tbl[0].seq[7-i], i == 0, 1, 1, 0);
    step(0, 1, 1, 0, 1, 1, 0);
    chk("par_err_pulse", parity_err, 1);
    idle(1);
    chk("par_err_novalid", {word_valid, parity_err}, 0);
`endif

    for (int n = 0; n < 3000; n++)
      step($urandom_range(299) == 0, $urandom_range(9) < 7, 1'($urandom), $urandom_range(11) == 0,
           1'($urandom), 1'($urandom), $urandom_range(19) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
